alarmclock_pio_in: RTL and testbench

ALARMCLOCK_PIO_IN -- requirements
Module: alarmclock_pio_in

---
 rtl/alarmclock_pio_in.sv | 148 ++++++++++++++
 tb/tb_alarmclock_pio_in.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alarmclock_pio_in.sv
// -----------------------------------------------------------------------------
// alarmclock_pio_in
// Debounced parallel input port with edge capture and a level interrupt,
// exposed as an Avalon-MM slave (zero wait states, read latency 0).
//
// Parameters
//   DEBOUNCE_CYCLES : stable clocks needed before an input change is accepted
//                     (1..65535)
//   EDGE_TYPE       : 0 rising, 1 falling, 2 any edge
//
// Ports
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   [1:0]  word address (0 data, 1 reserved, 2 irqmask, 3 edgecapture)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   [31:0] write data
//   in_port     in   [31:0] asynchronous external inputs
//   readdata    out  [31:0] combinational read data
//   irq         out  level interrupt, |(edgecapture & irqmask)
// -----------------------------------------------------------------------------
module alarmclock_pio_in #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    input  logic [31:0] in_port,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;
    // The edge that loads a new candidate already sees s2 at its new value,
    // so it counts as the first stable edge; deb is loaded once the counter
    // has seen DEBOUNCE_CYCLES-2 further stable edges beyond that.
    localparam bit          SINGLE  = (DEBOUNCE_CYCLES == 1);
    localparam logic [15:0] THRESH  = (DEBOUNCE_CYCLES >= 2) ?
                                      16'(DEBOUNCE_CYCLES - 2) : 16'd0;

    logic [31:0] s1_q, s2_q;
    logic [31:0] cand_q, cand_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] deb_q, deb_d;
    logic [31:0] deb_prev_q;
    logic [31:0] irqmask_q, irqmask_d;
    logic [31:0] edgecap_q, edgecap_d;
    logic [31:0] edge_s;
    logic [31:0] clr_s;
    logic        wr_en_s;

    // Debounce: track a candidate value and count how long s2 has matched it.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = 16'd0;
            if (SINGLE) begin
                deb_d = s2_q;
            end else begin
                deb_d = deb_q;
            end
        end else begin
            if (cnt_q >= THRESH) begin
                deb_d = cand_q;
            end else begin
                deb_d = deb_q;
            end
            // Saturate so a long-stable input never wraps back into range.
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 16'd1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Per-bit edge detection on the debounced value.
    always_comb begin
        case (EDGE_TYPE)
            32'd0:   edge_s = deb_q & ~deb_prev_q;
            32'd1:   edge_s = ~deb_q & deb_prev_q;
            default: edge_s = deb_q ^ deb_prev_q;
        endcase
    end

    // Register-file write decode; a new edge wins over a same-cycle clear.
    always_comb begin
        wr_en_s = chipselect & ~write_n;
        if (wr_en_s && (address == 2'd2)) begin
            irqmask_d = writedata;
        end else begin
            irqmask_d = irqmask_q;
        end
        if (wr_en_s && (address == 2'd3)) begin
            clr_s = writedata;
        end else begin
            clr_s = 32'h0000_0000;
        end
        edgecap_d = (edgecap_q & ~clr_s) | edge_s;
    end

    // All state registers, cleared asynchronously on reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q       <= 32'h0000_0000;
            s2_q       <= 32'h0000_0000;
            cand_q     <= 32'h0000_0000;
            cnt_q      <= 16'd0;
            deb_q      <= 32'h0000_0000;
            deb_prev_q <= 32'h0000_0000;
            irqmask_q  <= 32'h0000_0000;
            edgecap_q  <= 32'h0000_0000;
        end else begin
            s1_q       <= in_port;
            s2_q       <= s1_q;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
        end
    end

    // Zero-latency read mux; reads never change state.
    always_comb begin
        case (address)
            2'd0:    readdata = deb_q;
            2'd1:    readdata = 32'h0000_0000;
            2'd2:    readdata = irqmask_q;
            2'd3:    readdata = edgecap_q;
            default: readdata = 32'h0000_0000;
        endcase
    end

    // Interrupt is built only from registered state, so in_port cannot glitch it.
    always_comb begin
        irq = |(edgecap_q & irqmask_q);
    end

endmodule

// File: tb/tb_alarmclock_pio_in.sv
module tb_alarmclock_pio_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        cs_a, cs_b;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] in_a, in_b;
    logic [31:0] rd_a, rd_b;
    logic        irq_a, irq_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alarmclock_pio_in #(.DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
        .write_n(write_n), .writedata(writedata), .in_port(in_a),
        .readdata(rd_a), .irq(irq_a)
    );

    alarmclock_pio_in #(.DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
        .write_n(write_n), .writedata(writedata), .in_port(in_b),
        .readdata(rd_b), .irq(irq_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input bit sel_b, input logic [1:0] a, input logic [31:0] exp, input string tag);
        address = a;
        #1;
        chk(tag, sel_b ? rd_b : rd_a, exp);
    endtask

    task automatic wr(input bit sel_b, input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        cs_a      = ~sel_b;
        cs_b      = sel_b;
        write_n   = 1'b0;
        tick(1);
        cs_a      = 1'b0;
        cs_b      = 1'b0;
        write_n   = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = 2'd0;
        cs_a      = 1'b0;
        cs_b      = 1'b0;
        write_n   = 1'b1;
        writedata = 32'h0;
        in_a      = 32'h0;
        in_b      = 32'h0;
        tick(3);

        // reset state
        rd(1'b0, 2'd0, 32'h0, "rst_data");
        rd(1'b0, 2'd2, 32'h0, "rst_mask");
        rd(1'b0, 2'd3, 32'h0, "rst_ecap");
        chk("rst_irq", {31'd0, irq_a}, 32'h0);
        reset_n = 1'b1;

        // quiet start: no spurious capture in first D+2 clocks
        tick(6);
        rd(1'b0, 2'd0, 32'h0, "quiet_data");
        rd(1'b0, 2'd3, 32'h0, "quiet_ecap");

        // basic debounce latency and capture
        in_a = 32'h0000_0005;
        tick(5);
        rd(1'b0, 2'd0, 32'h0, "lat_data_early");
        tick(1);
        rd(1'b0, 2'd0, 32'h0000_0005, "lat_data");
        rd(1'b0, 2'd3, 32'h0, "lat_ecap_early");
        tick(1);
        rd(1'b0, 2'd3, 32'h0000_0005, "lat_ecap");
        chk("lat_irq_masked", {31'd0, irq_a}, 32'h0);
        wr(1'b0, 2'd3, 32'h0000_0005);
        rd(1'b0, 2'd3, 32'h0, "w1c_all");

        // interrupt on bit 0 rising edge
        wr(1'b0, 2'd2, 32'h0000_0001);
        in_a = 32'h0;
        tick(10);
        rd(1'b0, 2'd3, 32'h0, "fall_no_cap");
        in_a = 32'h0000_0001;
        tick(6);
        chk("irq_early", {31'd0, irq_a}, 32'h0);
        tick(1);
        chk("irq_set", {31'd0, irq_a}, 32'h1);
        wr(1'b0, 2'd3, 32'h0000_0001);
        chk("irq_clr", {31'd0, irq_a}, 32'h0);
        rd(1'b0, 2'd3, 32'h0, "ecap_clr");

        // short pulse on bit 3 is rejected
        in_a = 32'h0000_0009;
        tick(3);
        in_a = 32'h0000_0001;
        tick(10);
        rd(1'b0, 2'd0, 32'h0000_0001, "glitch_data");
        rd(1'b0, 2'd3, 32'h0, "glitch_ecap");

        // register map: read-only data, reserved word, mask read-back
        wr(1'b0, 2'd0, 32'h1234_5678);
        wr(1'b0, 2'd1, 32'h1234_5678);
        rd(1'b0, 2'd0, 32'h0000_0001, "ro_data");
        rd(1'b0, 2'd1, 32'h0, "rsvd");
        wr(1'b0, 2'd2, 32'hA5A5_A5A5);
        rd(1'b0, 2'd2, 32'hA5A5_A5A5, "mask_rb");

        // reset mid-debounce, then re-capture after release
        in_a = 32'hFFFF_FFFF;
        tick(3);
        reset_n = 1'b0;
        #1;
        rd(1'b0, 2'd0, 32'h0, "midrst_data");
        rd(1'b0, 2'd2, 32'h0, "midrst_mask");
        rd(1'b0, 2'd3, 32'h0, "midrst_ecap");
        chk("midrst_irq", {31'd0, irq_a}, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(6);
        rd(1'b0, 2'd0, 32'hFFFF_FFFF, "post_rst_data");
        rd(1'b0, 2'd3, 32'h0, "post_rst_ecap_early");
        tick(1);
        rd(1'b0, 2'd3, 32'hFFFF_FFFF, "post_rst_ecap");
        chk("post_rst_irq", {31'd0, irq_a}, 32'h0);

        // any-edge instance: bit 7 rises then falls
        in_b = 32'h0000_0080;
        tick(7);
        rd(1'b1, 2'd3, 32'h0000_0080, "any_rise");
        wr(1'b1, 2'd3, 32'h0000_0080);
        rd(1'b1, 2'd3, 32'h0, "any_rise_clr");
        in_b = 32'h0;
        tick(6);
        rd(1'b1, 2'd0, 32'h0, "any_fall_data");
        // clear lands on the same edge that records the falling edge
        wr(1'b1, 2'd3, 32'h0000_0080);
        rd(1'b1, 2'd3, 32'h0000_0080, "set_wins");
        wr(1'b1, 2'd3, 32'h0000_0080);
        rd(1'b1, 2'd3, 32'h0, "any_final_clr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
